score_counter: RTL and testbench

BCD score keeper for the Snakes game. It counts apple-eaten pulses into a two-digit decimal score, tracks the session high score, and runs a PLAY/OVER state machine. It drives the two digit inputs and enables of the downstream seven-segment decoders directly. Leading-zero blanking and game-over blinking are done here through the decoder enables, so the decoders stay purely combinational.

---
 rtl/score_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 45 ++++
 rtl/score_counter.sv | 154 +++++++++++++++
 tb/tb_score_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the Snakes score keeper.
//   bcd_t         : one BCD digit (0..9, never 10..15)
//   score_state_t : PLAY / OVER game state
//   BCD_MAX       : largest BCD digit value
//   bcd2_inc()    : increments a two-digit BCD value {tens, ones}
// -----------------------------------------------------------------------------
package score_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic {
      PLAY = 1'b0,
      OVER = 1'b1
   } score_state_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Caller guarantees the value is below 99, so the tens digit never wraps.
   function automatic logic [7:0] bcd2_inc(input bcd_t t, input bcd_t o);
      if (o == BCD_MAX) begin
         return {t + 4'd1, 4'd0};
      end
      return {t, o + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal counter digit, 0..9, wrapping to 0 with a carry out.
// Ports:
//   clk   in  system clock
//   nrst  in  synchronous active-low reset (digit -> 0)
//   clr   in  synchronous clear (digit -> 0), priority over inc
//   inc   in  count enable
//   digit out current BCD value
//   carry out inc && digit == 9 (combinational)
// -----------------------------------------------------------------------------
module bcd_digit
   import score_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   bcd_t digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/score_counter.sv
// -----------------------------------------------------------------------------
// score_counter
// Two-digit BCD score keeper with session high score and PLAY/OVER state.
// Drives the seven-segment decoder digits and enables directly; leading-zero
// blanking of the tens digit and game-over blinking happen via the enables.
// Optional feature macro: SCORE_BLINK_EN (builds the blink counter/phase).
// Parameters:
//   MAX_SCORE  saturation value, 1..99
//   BLINK_DIV  clk cycles per blink half-period in OVER (>= 2)
// Ports:
//   clk, nrst                clock, synchronous active-low reset
//   inc, game_over, restart  one-cycle event pulses
//   ones, tens               current score digits (BCD)
//   ones_en, tens_en         decoder enables
//   hi_ones, hi_tens         high score digits (BCD)
//   max_reached              score == MAX_SCORE
//   over                     state is OVER
// -----------------------------------------------------------------------------
module score_counter
   import score_pkg::*;
#(
   parameter int unsigned MAX_SCORE = 99,
   parameter int unsigned BLINK_DIV = 6_000_000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       inc,
   input  logic       game_over,
   input  logic       restart,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       ones_en,
   output logic       tens_en,
   output logic [3:0] hi_ones,
   output logic [3:0] hi_tens,
   output logic       max_reached,
   output logic       over
);

   localparam bcd_t MAX_TENS = bcd_t'(MAX_SCORE / 10);
   localparam bcd_t MAX_ONES = bcd_t'(MAX_SCORE % 10);

   score_state_t state_q, state_d;
   bcd_t         hi_ones_q, hi_ones_d;
   bcd_t         hi_tens_q, hi_tens_d;
   logic         at_max;
   logic         in_over;
   logic         inc_ones;
   logic         ones_carry;
   logic         tens_carry_unused;
   logic         blink_on;
   logic [7:0]   score_nxt;

   assign in_over  = (state_q == OVER);
   assign at_max   = (tens == MAX_TENS) && (ones == MAX_ONES);
   // Saturation gate: only the ones digit needs it, tens follows its carry.
   assign inc_ones = inc && !restart && !in_over && !at_max;

   bcd_digit u_ones (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (restart),
      .inc   (inc_ones),
      .digit (ones),
      .carry (ones_carry)
   );

   bcd_digit u_tens (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (restart),
      .inc   (ones_carry),
      .digit (tens),
      .carry (tens_carry_unused)
   );

   // score_nxt is the score the digits will hold after this edge, so an
   // inc coinciding with game_over is already included in the high-score compare.
   always_comb begin
      state_d   = state_q;
      hi_ones_d = hi_ones_q;
      hi_tens_d = hi_tens_q;
      score_nxt = inc_ones ? bcd2_inc(tens, ones) : {tens, ones};
      if (restart) begin
         state_d = PLAY;
      end else if (!in_over && game_over) begin
         state_d = OVER;
         // Packed BCD digits compare correctly as a plain binary number.
         if (score_nxt > {hi_tens_q, hi_ones_q}) begin
            hi_tens_d = score_nxt[7:4];
            hi_ones_d = score_nxt[3:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= PLAY;
         hi_ones_q <= '0;
         hi_tens_q <= '0;
      end else begin
         state_q   <= state_d;
         hi_ones_q <= hi_ones_d;
         hi_tens_q <= hi_tens_d;
      end
   end

`ifdef SCORE_BLINK_EN
   localparam int unsigned CW = $clog2(BLINK_DIV);

   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q, blink_ph_d;

   // Counter is held cleared outside OVER, so every OVER entry starts at 0/phase 1.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (restart || !in_over) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b1;
      end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         blink_ph_d  = !blink_ph_q;
      end else begin
         blink_cnt_d = blink_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end

   assign blink_on = blink_ph_q;
`else
   // BLINK_DIV only matters when blinking is built in.
   localparam int unsigned blink_div_unused = BLINK_DIV;

   assign blink_on = 1'b1;
`endif

   assign ones_en     = !in_over || blink_on;
   assign tens_en     = (tens != '0) && (!in_over || blink_on);
   assign max_reached = at_max;
   assign over        = in_over;
   assign hi_ones     = hi_ones_q;
   assign hi_tens     = hi_tens_q;

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;

   localparam int unsigned MAXS = 37;
   localparam int unsigned BD   = 4;

`ifdef SCORE_BLINK_EN
   localparam bit BLINKS = 1'b1;
`else
   localparam bit BLINKS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       nrst, inc, game_over, restart;
   logic [3:0] ones, tens, hi_ones, hi_tens;
   logic       ones_en, tens_en, max_reached, over;

   always #5 clk = ~clk;

   score_counter #(
      .MAX_SCORE (MAXS),
      .BLINK_DIV (BD)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .inc         (inc),
      .game_over   (game_over),
      .restart     (restart),
      .ones        (ones),
      .tens        (tens),
      .ones_en     (ones_en),
      .tens_en     (tens_en),
      .hi_ones     (hi_ones),
      .hi_tens     (hi_tens),
      .max_reached (max_reached),
      .over        (over)
   );

   typedef struct {
      int unsigned ones, tens, hi_ones, hi_tens;
      bit          ones_en, tens_en, maxr, over;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: decimal score, high score, game-over flag, and
   // number of cycles spent in OVER since entry.
   int unsigned m_score = 0, m_hi = 0, m_age = 0;
   bit          m_over = 1'b0;

   task automatic step(input bit n, input bit i, input bit g, input bit r);
      exp_t e;
      bit   ph, blank;
      @(negedge clk);
      nrst = n; inc = i; game_over = g; restart = r;
      if (!n) begin
         m_score = 0; m_hi = 0; m_over = 1'b0; m_age = 0;
      end else if (r) begin
         m_score = 0; m_over = 1'b0; m_age = 0;
      end else if (!m_over) begin
         if (i && m_score < MAXS) m_score = m_score + 1;
         if (g) begin
            if (m_score > m_hi) m_hi = m_score;
            m_over = 1'b1;
            m_age  = 0;
         end
      end else begin
         m_age = m_age + 1;
      end
      ph        = ((m_age / BD) % 2) == 0;
      blank     = m_over && BLINKS && !ph;
      e.ones    = m_score % 10;
      e.tens    = m_score / 10;
      e.hi_ones = m_hi % 10;
      e.hi_tens = m_hi / 10;
      e.ones_en = !blank;
      e.tens_en = (m_score >= 10) && !blank;
      e.maxr    = (m_score == MAXS);
      e.over    = m_over;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a new output set, compare it with
   // the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ones",        {4'd0, ones},        8'(e.ones));
            chk("tens",        {4'd0, tens},        8'(e.tens));
            chk("hi_ones",     {4'd0, hi_ones},     8'(e.hi_ones));
            chk("hi_tens",     {4'd0, hi_tens},     8'(e.hi_tens));
            chk("ones_en",     {7'd0, ones_en},     {7'd0, e.ones_en});
            chk("tens_en",     {7'd0, tens_en},     {7'd0, e.tens_en});
            chk("max_reached", {7'd0, max_reached}, {7'd0, e.maxr});
            chk("over",        {7'd0, over},        {7'd0, e.over});
         end
      end
   end

   initial begin
      int w;
      nrst = 1'b0; inc = 1'b0; game_over = 1'b0; restart = 1'b0;

      // Reset, then idle: tens blanked, ones shown.
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      // 12 increments: passes 9 -> 10 wrap with carry, ends at 12.
      repeat (12) step(1, 1, 0, 0);
      step(1, 0, 0, 0);

      // Score 23, then inc + game_over together -> hi 24.
      step(1, 0, 0, 1);
      repeat (23) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      repeat (3) step(1, 1, 1, 0);   // ignored in OVER
      step(1, 0, 0, 1);              // restart keeps hi
      repeat (10) step(1, 1, 0, 0);
      step(1, 0, 1, 0);              // 10 < 24: hi stays
      step(1, 0, 0, 1);

      // restart, game_over and inc in one cycle at 07.
      repeat (7) step(1, 1, 0, 0);
      step(1, 1, 1, 1);
      step(1, 0, 0, 0);

      // Saturation at MAXS, including inc+game_over while saturated.
      repeat (MAXS + 8) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(1, 0, 0, 1);

      // Blink: score 05 in OVER, watch several half-periods.
      repeat (5) step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      repeat (3 * BD + 2) step(1, 0, 0, 0);
      // Two-digit score in OVER blinks both enables.
      step(1, 0, 0, 1);
      repeat (15) step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      repeat (2 * BD + 1) step(1, 0, 0, 0);

      // Randomized traffic, including resets mid-game.
      repeat (3000) begin
         step($urandom_range(0, 199) != 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 59) == 0);
      end
      // Long OVER stretches to exercise the blink across many periods.
      repeat (200) begin
         step(1, $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 39) == 0);
      end

      w = 0;
      while (q.size() > 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      #2;
      checks++;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
